// File: rtl/conv_mc_seq_pkg.sv
// conv_mc_seq_pkg: state encoding and sizing helpers shared by the convolution engines
package conv_mc_seq_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // output extent of one dimension after kernel, padding and stride
    function automatic int res_dim(input int img_n, input int k_n, input int pad, input int stride);
        return (img_n - k_n + 2 * pad) / stride + 1;
    endfunction

endpackage

// File: rtl/conv_mc_seq_mac_sat.sv
// conv_mc_seq_mac_sat: one signed MAC step, with bias, ReLU and saturation on an output's last tap
module conv_mc_seq_mac_sat #(
    parameter int BITWIDTH = 4,
    parameter int ACC_W = 9,
    parameter int RELU_EN = 0
) (
    input  logic signed [BITWIDTH-1:0] pixel,
    input  logic signed [BITWIDTH-1:0] weight,
    input  logic signed [BITWIDTH-1:0] bias,
    input  logic signed [ACC_W-1:0]    acc,
    input  logic                       last,
    output logic signed [ACC_W-1:0]    y
);
    localparam int RW = 2 * BITWIDTH;
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-RW+1){1'b1}}, {(RW-1){1'b0}}};

    logic signed [RW-1:0]    prod;
    logic signed [ACC_W-1:0] sum, val, rl;

    // low RW bits of the sign-extended product are exact since the product always fits in RW
    always_comb begin
        prod = {{BITWIDTH{pixel[BITWIDTH-1]}}, pixel} * {{BITWIDTH{weight[BITWIDTH-1]}}, weight};
        sum  = acc + {{(ACC_W-RW){prod[RW-1]}}, prod};
        val  = sum + {{(ACC_W-BITWIDTH){bias[BITWIDTH-1]}}, bias};
        rl   = (RELU_EN != 0 && val < 0) ? '0 : val;
        y    = !last ? sum : rl > MAXV ? MAXV : rl < MINV ? MINV : rl;
    end

endmodule

// File: rtl/conv_mc_seq.sv
// conv_mc_seq: sequential multi-channel 2-D convolution, one MAC per clock over a latched frame
module conv_mc_seq
    import conv_mc_seq_pkg::*;
#(
    parameter int IMG_W    = 4,
    parameter int IMG_H    = 4,
    parameter int K_W      = 2,
    parameter int K_H      = 2,
    parameter int IN_CH    = 1,
    parameter int BITWIDTH = 4,
    parameter int PAD_EN   = 0,
    parameter int PADDING  = 0,
    parameter int STRIDE   = 1,
    parameter int RELU_EN  = 0,
    localparam int PAD     = PADDING * PAD_EN,
    localparam int RES_W   = res_dim(IMG_W, K_W, PAD, STRIDE),
    localparam int RES_H   = res_dim(IMG_H, K_H, PAD, STRIDE),
    localparam int N_OUT   = RES_W * RES_H,
    localparam int RW      = 2 * BITWIDTH
) (
    input  logic                                   clk_en,
    input  logic                                   rst_n,
    input  logic                                   conv_en,
    input  logic [IMG_W*IMG_H*IN_CH*BITWIDTH-1:0]  img,
    input  logic [K_W*K_H*IN_CH*BITWIDTH-1:0]      weight,
    input  logic [BITWIDTH-1:0]                    bias,
    output logic [RW*N_OUT-1:0]                    result,
    output logic                                   conv_fin,
    output logic                                   busy
);
    localparam int TAPS     = K_W * K_H * IN_CH;
    localparam int ACC_W    = RW + clog2(TAPS) + 1;
    localparam int IMG_BITS = IMG_W * IMG_H * IN_CH * BITWIDTH;
    localparam int WGT_BITS = K_W * K_H * IN_CH * BITWIDTH;
    localparam int IIW      = clog2(IMG_BITS);
    localparam int WIW      = clog2(WGT_BITS);
    localparam int RIW      = clog2(RW * N_OUT);
    localparam int CW       = 16;

    state_t                     state, nstate;
    logic [IMG_BITS-1:0]        img_r;
    logic [WGT_BITS-1:0]        wgt_r;
    logic signed [BITWIDTH-1:0] bias_r, pix, wgt;
    logic signed [ACC_W-1:0]    acc, y;
    logic [CW-1:0]              kc, kr, ch, oc, orow;
    logic signed [31:0]         pr, pc, ch_s;
    logic [IIW-1:0]             pidx;
    logic [RIW-1:0]             ridx;
    logic                       in_rng, kc_w, kr_w, ch_w, oc_w, or_w, last_tap, last_out;

    // decode the current tap: wrap flags, source coordinates and operand/result slice positions
    always_comb begin
        kc_w     = kc == CW'(K_W - 1);
        kr_w     = kr == CW'(K_H - 1);
        ch_w     = ch == CW'(IN_CH - 1);
        oc_w     = oc == CW'(RES_W - 1);
        or_w     = orow == CW'(RES_H - 1);
        last_tap = kc_w && kr_w && ch_w;
        last_out = oc_w && or_w;
        ch_s     = $signed(32'(ch));
        pr       = $signed(32'(orow)) * STRIDE + $signed(32'(kr)) - PAD;
        pc       = $signed(32'(oc)) * STRIDE + $signed(32'(kc)) - PAD;
        in_rng   = pr >= 0 && pr < IMG_H && pc >= 0 && pc < IMG_W;
        pidx     = in_rng ? IIW'(((ch_s * IMG_H + pr) * IMG_W + pc) * BITWIDTH) : '0;
        pix      = in_rng ? img_r[pidx +: BITWIDTH] : '0;
        wgt      = wgt_r[WIW'(((ch_s * K_H + $signed(32'(kr))) * K_W + $signed(32'(kc))) * BITWIDTH) +: BITWIDTH];
        ridx     = RIW'(($signed(32'(orow)) * RES_W + $signed(32'(oc))) * RW);
    end

    conv_mc_seq_mac_sat #(
        .BITWIDTH(BITWIDTH),
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
    ) u_mac (
        .pixel (pix),
        .weight(wgt),
        .bias  (bias_r),
        .acc   (acc),
        .last  (last_tap),
        .y     (y)
    );

    // state register
    always_ff @(posedge clk_en) state <= !rst_n ? IDLE : nstate;

    // accept in IDLE, leave RUN on the frame's final tap, DONE lasts exactly one cycle
    always_comb
        nstate = state == IDLE ? (conv_en ? RUN : IDLE) : state == RUN ? (last_tap && last_out ? DONE : RUN) : IDLE;

    // status outputs decode straight from state
    always_comb begin
        busy     = state != IDLE;
        conv_fin = state == DONE;
    end

    // operand latch, tap/output counters, accumulator and result write-back
    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            img_r  <= '0;
            wgt_r  <= '0;
            bias_r <= '0;
            acc    <= '0;
            kc     <= '0;
            kr     <= '0;
            ch     <= '0;
            oc     <= '0;
            orow   <= '0;
            result <= '0;
        end else if (state == IDLE && conv_en) begin
            img_r  <= img;
            wgt_r  <= weight;
            bias_r <= bias;
            acc    <= '0;
            kc     <= '0;
            kr     <= '0;
            ch     <= '0;
            oc     <= '0;
            orow   <= '0;
        end else if (state == RUN) begin
            acc  <= last_tap ? '0 : y;
            if (last_tap) result[ridx +: RW] <= y[RW-1:0];
            kc   <= kc_w ? '0 : kc + 1'b1;
            kr   <= kc_w ? (kr_w ? '0 : kr + 1'b1) : kr;
            ch   <= (kc_w && kr_w) ? (ch_w ? '0 : ch + 1'b1) : ch;
            oc   <= last_tap ? (oc_w ? '0 : oc + 1'b1) : oc;
            orow <= (last_tap && oc_w) ? (or_w ? '0 : orow + 1'b1) : orow;
        end
    end

endmodule

// File: tb/tb_conv_mc_seq.sv
// tb_conv_mc_seq: scenario tests of conv_mc_seq across five configurations against a direct convolution model
module tb_conv_mc_seq;

    typedef int iq_t[$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   go = '0;
    logic [63:0]  img_a = '0;
    logic [127:0] img_b = '0;
    logic [15:0]  w_a = '0;
    logic [31:0]  w_b = '0;
    logic [35:0]  w_c = '0;
    logic [3:0]   bias = '0;
    wire  [71:0]  r0, r2, r3;
    wire  [127:0] r1;
    wire  [31:0]  r4;
    wire  [4:0]   fin, bsy;
    int           checks = 0, passed = 0;

    always #5 clk = ~clk;

    conv_mc_seq u0 (.clk_en(clk), .rst_n(rst_n), .conv_en(go[0]), .img(img_a), .weight(w_a), .bias(bias),
                    .result(r0), .conv_fin(fin[0]), .busy(bsy[0]));
    conv_mc_seq #(.K_W(3), .K_H(3), .PAD_EN(1), .PADDING(1)) u1 (.clk_en(clk), .rst_n(rst_n), .conv_en(go[1]),
                    .img(img_a), .weight(w_c), .bias(bias), .result(r1), .conv_fin(fin[1]), .busy(bsy[1]));
    conv_mc_seq #(.IN_CH(2)) u2 (.clk_en(clk), .rst_n(rst_n), .conv_en(go[2]), .img(img_b), .weight(w_b), .bias(bias),
                    .result(r2), .conv_fin(fin[2]), .busy(bsy[2]));
    conv_mc_seq #(.RELU_EN(1)) u3 (.clk_en(clk), .rst_n(rst_n), .conv_en(go[3]), .img(img_a), .weight(w_a), .bias(bias),
                    .result(r3), .conv_fin(fin[3]), .busy(bsy[3]));
    conv_mc_seq #(.STRIDE(2)) u4 (.clk_en(clk), .rst_n(rst_n), .conv_en(go[4]), .img(img_a), .weight(w_a), .bias(bias),
                    .result(r4), .conv_fin(fin[4]), .busy(bsy[4]));

    function automatic int s4(input int x);
        int v;
        v = x & 15;
        return v >= 8 ? v - 16 : v;
    endfunction

    function automatic iq_t fill(input int n, input int v);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(v);
        return q;
    endfunction

    function automatic iq_t rnd(input int n);
        iq_t q;
        for (int i = 0; i < n; i++) q.push_back(s4(int'($urandom_range(15, 0))));
        return q;
    endfunction

    function automatic void cfg(input int sel, output int kw, output int ic, output int pad, output int st, output int relu);
        kw   = sel == 1 ? 3 : 2;
        ic   = sel == 2 ? 2 : 1;
        pad  = sel == 1 ? 1 : 0;
        st   = sel == 4 ? 2 : 1;
        relu = sel == 3 ? 1 : 0;
    endfunction

    // direct convolution on 4x4 images: sum over window plus bias, optional ReLU, clamp to 8-bit signed
    function automatic void model(input int kw, input int ic, input int pad, input int st, input int relu,
                                  input iq_t pix, input iq_t wts, input int b, output iq_t q);
        int rw, s, y, x;
        q = {};
        rw = (4 - kw + 2 * pad) / st + 1;
        for (int r = 0; r < rw; r++)
            for (int c = 0; c < rw; c++) begin
                s = b;
                for (int h = 0; h < ic; h++)
                    for (int i = 0; i < kw; i++)
                        for (int j = 0; j < kw; j++) begin
                            y = r * st + i - pad;
                            x = c * st + j - pad;
                            if (y >= 0 && y < 4 && x >= 0 && x < 4)
                                s += pix[(h * 4 + y) * 4 + x] * wts[(h * kw + i) * kw + j];
                        end
                if (relu != 0 && s < 0) s = 0;
                q.push_back(s > 127 ? 127 : s < -128 ? -128 : s);
            end
    endfunction

    function automatic logic [127:0] res_of(input int sel);
        case (sel)
            0: return 128'(r0);
            1: return r1;
            2: return 128'(r2);
            3: return 128'(r3);
            default: return 128'(r4);
        endcase
    endfunction

    task automatic load(input iq_t pix, input iq_t wts, input int b);
        for (int i = 0; i < 16; i++) img_a[i*4 +: 4] = 4'(pix[i]);
        if (pix.size() == 32) for (int i = 0; i < 32; i++) img_b[i*4 +: 4] = 4'(pix[i]);
        if (wts.size() == 4) for (int i = 0; i < 4; i++) w_a[i*4 +: 4] = 4'(wts[i]);
        if (wts.size() == 8) for (int i = 0; i < 8; i++) w_b[i*4 +: 4] = 4'(wts[i]);
        if (wts.size() == 9) for (int i = 0; i < 9; i++) w_c[i*4 +: 4] = 4'(wts[i]);
        bias = 4'(b);
    endtask

    // pulse conv_en, count edges until conv_fin (bounded), optionally poke conv_en mid-run
    task automatic run(input int sel, input int inj, output int n, output int lapses, output logic fa, output logic ba);
        @(negedge clk);
        go[sel] = 1'b1;
        @(posedge clk); #1;
        go[sel] = 1'b0;
        n = 0;
        lapses = 0;
        while (!fin[sel] && n < 400) begin
            if (!bsy[sel]) lapses++;
            go[sel] = inj != 0 && n == inj;
            @(posedge clk); #1;
            n++;
        end
        go[sel] = 1'b0;
        if (!bsy[sel]) lapses++;
        @(posedge clk); #1;
        fa = fin[sel];
        ba = bsy[sel];
    endtask

    task automatic exec(input int sel, input iq_t pix, input iq_t wts, input int b, input int inj,
                        output iq_t q, output int t, output int n, output int lapses, output logic fa, output logic ba);
        int kw, ic, pad, st, relu;
        cfg(sel, kw, ic, pad, st, relu);
        load(pix, wts, b);
        model(kw, ic, pad, st, relu, pix, wts, b, q);
        t = q.size() * kw * kw * ic;
        run(sel, inj, n, lapses, fa, ba);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (fin !== 5'b0 || bsy !== 5'b0) $display("FAIL reset_status: fin %b busy %b, want 00000 00000", fin, bsy);
        else passed++;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (res_of(s) !== '0) $display("FAIL reset_result%0d: got %h want 0", s, res_of(s));
            else passed++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ones;
        iq_t q;
        int t, n, lapses;
        logic fa, ba;
        logic [127:0] rr;
        exec(0, fill(16, 1), fill(4, 1), 1, 0, q, t, n, lapses, fa, ba);
        checks++;
        if (n !== 36) $display("FAIL ones_latency: conv_fin after %0d edges, want 36", n);
        else passed++;
        checks++;
        if (lapses !== 0 || fa !== 1'b0 || ba !== 1'b0)
            $display("FAIL ones_handshake: busy lapses %0d, fin/busy after %b%b, want 0 and 00", lapses, fa, ba);
        else passed++;
        rr = res_of(0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'h05) $display("FAIL ones_res%0d: got %h want 05", i, rr[i*8 +: 8]);
            else passed++;
        end
    endtask

    task automatic test_padding;
        iq_t q;
        int t, n, lapses, e;
        logic fa, ba;
        logic [127:0] rr;
        exec(1, fill(16, 1), fill(9, 1), 1, 0, q, t, n, lapses, fa, ba);
        checks++;
        if (n !== 144) $display("FAIL pad_latency: conv_fin after %0d edges, want 144", n);
        else passed++;
        rr = res_of(1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                e = (r == 0 || r == 3 ? 2 : 3) * (c == 0 || c == 3 ? 2 : 3) + 1;
                checks++;
                if (rr[(r*4+c)*8 +: 8] !== 8'(e)) $display("FAIL pad_res_%0d_%0d: got %h want %h", r, c, rr[(r*4+c)*8 +: 8], 8'(e));
                else passed++;
            end
    endtask

    task automatic test_multi_channel;
        iq_t q, pix;
        int t, n, lapses;
        logic fa, ba;
        logic [127:0] rr;
        pix = fill(16, 1);
        for (int i = 0; i < 16; i++) pix.push_back(2);
        exec(2, pix, fill(8, 1), 1, 0, q, t, n, lapses, fa, ba);
        checks++;
        if (n !== 72 || lapses !== 0) $display("FAIL mc_latency: conv_fin after %0d edges (busy lapses %0d), want 72 and 0", n, lapses);
        else passed++;
        rr = res_of(2);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'd13) $display("FAIL mc_res%0d: got %h want 0d", i, rr[i*8 +: 8]);
            else passed++;
        end
    endtask

    task automatic test_saturation;
        iq_t q;
        int t, n, lapses;
        logic fa, ba;
        logic [127:0] rr;
        exec(0, fill(16, -8), fill(4, -8), 0, 0, q, t, n, lapses, fa, ba);
        rr = res_of(0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'h7F) $display("FAIL sat_res%0d: got %h want 7f", i, rr[i*8 +: 8]);
            else passed++;
        end
        exec(0, fill(16, 1), fill(4, -1), 1, 0, q, t, n, lapses, fa, ba);
        rr = res_of(0);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'hFD) $display("FAIL neg_res%0d: got %h want fd", i, rr[i*8 +: 8]);
            else passed++;
        end
        exec(3, fill(16, 1), fill(4, -1), 1, 0, q, t, n, lapses, fa, ba);
        rr = res_of(3);
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'h00) $display("FAIL relu_res%0d: got %h want 00", i, rr[i*8 +: 8]);
            else passed++;
        end
    endtask

    task automatic test_reset_midrun;
        iq_t q;
        int t, n, lapses;
        logic fa, ba;
        logic [127:0] rr;
        load(rnd(16), rnd(4), 3);
        @(negedge clk);
        go[0] = 1'b1;
        @(posedge clk); #1;
        go[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (r0 !== '0 || fin[0] !== 1'b0 || bsy[0] !== 1'b0)
            $display("FAIL midrun_reset: result %h fin %b busy %b, want 0 0 0", r0, fin[0], bsy[0]);
        else passed++;
        exec(0, rnd(16), rnd(4), s4(int'($urandom_range(15, 0))), 0, q, t, n, lapses, fa, ba);
        checks++;
        if (n !== t) $display("FAIL midrun_latency: conv_fin after %0d edges, want %0d", n, t);
        else passed++;
        rr = res_of(0);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'(q[i])) $display("FAIL midrun_res%0d: got %h want %h", i, rr[i*8 +: 8], 8'(q[i]));
            else passed++;
        end
    endtask

    task automatic test_stride;
        iq_t q, pix;
        int t, n, lapses;
        logic fa, ba;
        logic [127:0] rr;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pix.push_back(s4(r * 4 + c));
        exec(4, pix, fill(4, 1), 1, 5, q, t, n, lapses, fa, ba);
        checks++;
        if (n !== 16 || lapses !== 0) $display("FAIL stride_latency: conv_fin after %0d edges (busy lapses %0d), want 16 and 0", n, lapses);
        else passed++;
        checks++;
        if (fa !== 1'b0 || ba !== 1'b0) $display("FAIL stride_idle: fin/busy after %b%b, want 00", fa, ba);
        else passed++;
        rr = res_of(4);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rr[i*8 +: 8] !== 8'(q[i])) $display("FAIL stride_res%0d: got %h want %h", i, rr[i*8 +: 8], 8'(q[i]));
            else passed++;
        end
    endtask

    task automatic test_random;
        iq_t q;
        int t, n, lapses, kw, ic, pad, st, relu;
        logic fa, ba;
        logic [127:0] rr;
        for (int s = 0; s < 5; s++)
            for (int k = 0; k < 2; k++) begin
                cfg(s, kw, ic, pad, st, relu);
                exec(s, rnd(16 * ic), rnd(kw * kw * ic), s4(int'($urandom_range(15, 0))), 0, q, t, n, lapses, fa, ba);
                checks++;
                if (n !== t || lapses !== 0 || fa !== 1'b0 || ba !== 1'b0)
                    $display("FAIL rand%0d_%0d_timing: %0d edges, lapses %0d, after %b%b; want %0d, 0, 00", s, k, n, lapses, fa, ba, t);
                else passed++;
                rr = res_of(s);
                for (int i = 0; i < q.size(); i++) begin
                    checks++;
                    if (rr[i*8 +: 8] !== 8'(q[i])) $display("FAIL rand%0d_%0d_res%0d: got %h want %h", s, k, i, rr[i*8 +: 8], 8'(q[i]));
                    else passed++;
                end
            end
    endtask

    initial begin
        test_reset;
        test_ones;
        test_padding;
        test_multi_channel;
        test_saturation;
        test_reset_midrun;
        test_stride;
        test_random;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
